// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch: sequential advance, stall hold,
// buffered branch redirects and highest-priority flush redirects.
module pc_gen #(
  parameter int ADDR_W = 32,
  parameter int INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               addr_err
);

  // Mask form keeps INST_BYTES=1 legal (no zero-width slice of the low bits).
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;

  logic unused_stall;
  assign unused_stall = ^(stall >> 1);

  function automatic logic [ADDR_W-1:0] aligned(input logic [ADDR_W-1:0] x);
    return x & ~LOW_MASK;
  endfunction

  function automatic logic misaligned(input logic [ADDR_W-1:0] x);
    return |(x & LOW_MASK);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_VEC;
      ce          <= 1'b0;
      addr_err    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          state      <= RUN;
          ce         <= 1'b1;
          pc         <= RESET_VEC;
          pend_valid <= 1'b0;
        end
        default: begin
          ce <= 1'b1;
          if (flush) begin
            pc         <= aligned(new_pc);
            addr_err   <= misaligned(new_pc);
            pend_valid <= 1'b0;
          end else if (stall[0]) begin
            // Only the newest branch seen during a stall is kept.
            if (branch_flag) begin
              pend_valid  <= 1'b1;
              pend_target <= branch_target;
            end
          end else if (branch_flag) begin
            pc         <= aligned(branch_target);
            addr_err   <= misaligned(branch_target);
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            pc         <= aligned(pend_target);
            addr_err   <= misaligned(pend_target);
            pend_valid <= 1'b0;
          end else begin
            pc <= pc + STEP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: vector table for steady-state behaviour, plus hand
// sequences for reset release, async reset mid-cycle and address wrap.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic [31:0] pc;
  logic        ce, addr_err;

  logic        rst8 = 1'b1;
  logic [7:0]  pc8;
  logic        ce8, err8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_VEC(32'h100), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .new_pc(new_pc),
    .pc(pc), .ce(ce), .addr_err(addr_err)
  );

  pc_gen #(.ADDR_W(8), .INST_BYTES(4), .RESET_VEC(8'hF8), .STALL_W(6)) dut8 (
    .clk(clk), .rst(rst8), .stall(6'b0), .branch_flag(1'b0),
    .branch_target(8'h0), .flush(1'b0), .new_pc(8'h0),
    .pc(pc8), .ce(ce8), .addr_err(err8)
  );

  typedef struct {
    logic        s;
    logic        bf;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] np;
    logic [31:0] epc;
    logic        ece;
    logic        eerr;
  } vec_t;

  vec_t v[30];

  function automatic vec_t mk(input logic s, input logic bf, input logic [31:0] bt,
                              input logic fl, input logic [31:0] np,
                              input logic [31:0] epc, input logic ece, input logic eerr);
    vec_t r;
    r.s = s; r.bf = bf; r.bt = bt; r.fl = fl; r.np = np;
    r.epc = epc; r.ece = ece; r.eerr = eerr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic bf, input logic [31:0] bt,
                       input logic fl, input logic [31:0] np);
    stall = {5'b10101, s};  // upper bits must be ignored
    branch_flag = bf; branch_target = bt; flush = fl; new_pc = np;
  endtask

  task automatic step(input string nm, input logic s, input logic bf, input logic [31:0] bt,
                      input logic fl, input logic [31:0] np,
                      input logic [31:0] epc, input logic ece, input logic eerr);
    drive(s, bf, bt, fl, np);
    @(posedge clk); #1;
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".ce"}, 32'(ce), 32'(ece));
    chk({nm, ".err"}, 32'(addr_err), 32'(eerr));
  endtask

  initial begin
    //        s  bf  bt            fl  np            pc            ce  err
    v[0]  = mk(0, 1, 32'h800,      1, 32'h200,       32'h100,      1, 0); // IDLE ignores
    v[1]  = mk(0, 0, 0,            0, 0,             32'h104,      1, 0);
    v[2]  = mk(0, 0, 0,            0, 0,             32'h108,      1, 0);
    v[3]  = mk(1, 0, 0,            0, 0,             32'h108,      1, 0);
    v[4]  = mk(1, 0, 0,            0, 0,             32'h108,      1, 0);
    v[5]  = mk(1, 0, 0,            0, 0,             32'h108,      1, 0);
    v[6]  = mk(0, 0, 0,            0, 0,             32'h10C,      1, 0);
    v[7]  = mk(1, 1, 32'h400,      0, 0,             32'h10C,      1, 0);
    v[8]  = mk(1, 0, 0,            0, 0,             32'h10C,      1, 0);
    v[9]  = mk(0, 0, 0,            0, 0,             32'h400,      1, 0);
    v[10] = mk(0, 0, 0,            0, 0,             32'h404,      1, 0);
    v[11] = mk(1, 1, 32'h500,      0, 0,             32'h404,      1, 0);
    v[12] = mk(1, 1, 32'h600,      0, 0,             32'h404,      1, 0);
    v[13] = mk(0, 0, 0,            0, 0,             32'h600,      1, 0);
    v[14] = mk(0, 0, 0,            0, 0,             32'h604,      1, 0);
    v[15] = mk(1, 1, 32'h400,      0, 0,             32'h604,      1, 0);
    v[16] = mk(0, 1, 32'h800,      0, 0,             32'h800,      1, 0);
    v[17] = mk(0, 0, 0,            0, 0,             32'h804,      1, 0);
    v[18] = mk(1, 1, 32'h400,      0, 0,             32'h804,      1, 0);
    v[19] = mk(0, 1, 32'h900,      1, 32'h180,       32'h180,      1, 0);
    v[20] = mk(0, 0, 0,            0, 0,             32'h184,      1, 0);
    v[21] = mk(1, 1, 32'h300,      1, 32'h500,       32'h500,      1, 0);
    v[22] = mk(0, 0, 0,            0, 0,             32'h504,      1, 0);
    v[23] = mk(0, 1, 32'h1002,     0, 0,             32'h1000,     1, 1);
    v[24] = mk(0, 0, 0,            0, 0,             32'h1004,     1, 0);
    v[25] = mk(0, 0, 0,            1, 32'h2003,      32'h2000,     1, 1);
    v[26] = mk(1, 0, 0,            0, 0,             32'h2000,     1, 0);
    v[27] = mk(1, 1, 32'h3001,     0, 0,             32'h2000,     1, 0);
    v[28] = mk(0, 0, 0,            0, 0,             32'h3000,     1, 1);
    v[29] = mk(0, 0, 0,            0, 0,             32'h3004,     1, 0);

    // 8-bit instance: reset release then wrap 0xFC -> 0x00.
    @(posedge clk); #1;
    chk("rst.pc", pc, 32'h100);
    chk("rst.ce", 32'(ce), 0);
    chk("rst.err", 32'(addr_err), 0);
    chk("w8.rst.pc", 32'(pc8), 32'hF8);
    rst8 = 1'b0;
    chk("w8.rst.ce", 32'(ce8), 0);
    @(posedge clk); #1;
    chk("w8.e1.pc", 32'(pc8), 32'hF8);
    chk("w8.e1.ce", 32'(ce8), 1);
    @(posedge clk); #1;
    chk("w8.e2.pc", 32'(pc8), 32'hFC);
    @(posedge clk); #1;
    chk("w8.e3.pc", 32'(pc8), 32'h00);
    @(posedge clk); #1;
    chk("w8.e4.pc", 32'(pc8), 32'h04);
    chk("w8.err", 32'(err8), 0);

    // Main instance, table vectors straight out of reset.
    chk("rst.hold.pc", pc, 32'h100);
    rst = 1'b0;
    for (int i = 0; i < 30; i++)
      step($sformatf("vec%0d", i), v[i].s, v[i].bf, v[i].bt, v[i].fl, v[i].np,
           v[i].epc, v[i].ece, v[i].eerr);

    // Async reset mid-cycle kills an in-flight addr_err pulse.
    step("pre1", 0, 1, 32'h1006, 0, 0, 32'h1004, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar1.pc", pc, 32'h100);
    chk("ar1.ce", 32'(ce), 0);
    chk("ar1.err", 32'(addr_err), 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    step("r1.idle", 0, 0, 0, 0, 0, 32'h100, 1, 0);
    step("r1.pend", 1, 1, 32'h700, 0, 0, 32'h100, 1, 0);

    // Async reset mid-cycle with a branch pending: pending must be lost.
    #2 rst = 1'b1;
    #1;
    chk("ar2.pc", pc, 32'h100);
    chk("ar2.ce", 32'(ce), 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    step("r2.e1", 0, 0, 0, 0, 0, 32'h100, 1, 0);
    step("r2.e2", 0, 0, 0, 0, 0, 32'h104, 1, 0);
    step("r2.e3", 0, 0, 0, 0, 0, 32'h108, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. It drives the instruction ROM address and chip enable, advances by one instruction per unstalled cycle, and accepts branch redirects from decode and exception redirects from the control unit. A branch that arrives while fetch is stalled is buffered and applied when the stall clears. It sits ahead of the IF/ID register and replaces the fixed-increment PC register.

## Interface
- `ADDR_W`, 32: PC / ROM address width in bits.
- `INST_BYTES`, 4: instruction size in bytes. Must be a power of two. `ALIGN_B = log2(INST_BYTES)`.
- `RESET_VEC`, 0: PC value while held in reset/idle. Must be `INST_BYTES`-aligned.
- `STALL_W`, 6: width of the pipeline stall vector. Bit 0 is the fetch stage.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `stall`, in, `STALL_W`: per-stage stall. Only `stall[0]` is used here.
- `branch_flag`, in, 1: decode requests a redirect this cycle.
- `branch_target`, in, `ADDR_W`: redirect address, qualified by `branch_flag`.
- `flush`, in, 1: exception/ERET redirect. Highest priority.
- `new_pc`, in, `ADDR_W`: flush target, qualified by `flush`.
- `pc`, out, `ADDR_W`: current fetch address to ROM.
- `ce`, out, 1: ROM chip enable.
- `addr_err`, out, 1: registered one-cycle pulse. Set when an accepted redirect target has non-zero low `ALIGN_B` bits.

## Operation
- State machine has two states, IDLE and RUN.
  - IDLE: `ce`=0, `pc`=`RESET_VEC`, pending buffer cleared. All inputs are ignored. Next state is always RUN.
  - RUN: `ce`=1. Stays in RUN until `rst`.
- Pending-branch buffer:
  - Holds `pend_valid` and `pend_target`.
  - Captures `branch_target` when `branch_flag`=1 and `stall[0]`=1.
- PC update in RUN, in strict priority order each edge:
  1. `flush`=1: `pc` <= aligned(`new_pc`). Clear `pend_valid`. Applies regardless of `stall[0]`.
  2. `stall[0]`=1: `pc` holds. If `branch_flag`, load buffer (a newer branch overwrites an older pending one).
  3. `branch_flag`=1: `pc` <= aligned(`branch_target`). Clear `pend_valid`. A fresh branch beats a stale pending one.
  4. `pend_valid`=1: `pc` <= aligned(`pend_target`). Clear `pend_valid`.
  5. Otherwise: `pc` <= `pc` + `INST_BYTES`.
- aligned(x) = x with the low `ALIGN_B` bits forced to 0.
- `addr_err` is set for one cycle on the edge where a redirect with misaligned low bits is applied to `pc` (rules 1, 3, 4). It is not set when the target is merely buffered.
- Arithmetic: the increment is modulo 2^`ADDR_W`. For example, `pc` = 2^`ADDR_W` − `INST_BYTES` wraps to 0. No overflow flag.

## Timing
- Reset values, asynchronously on `rst`=1: `pc`=`RESET_VEC`, `ce`=0, `addr_err`=0, `pend_valid`=0, state=IDLE.
- Reset deassertion:
  - First rising edge with `rst`=0: IDLE→RUN, `ce` becomes 1, `pc` still `RESET_VEC`.
  - Second edge: first increment to `RESET_VEC`+`INST_BYTES` (if unstalled).
- Redirect latency: a redirect presented in cycle N appears on `pc` after edge N, so the ROM sees the target in cycle N+1. There is no bubble inserted.
- Stall release: if `pend_valid` is set, the pending target is applied on the first edge with `stall[0]`=0.
- `rst` asserted mid-operation discards any pending branch and any in-flight `addr_err` pulse immediately. No state survives.
- `flush` together with `stall[0]` and `branch_flag` in the same cycle: flush wins, the branch is dropped, and the buffer is cleared.
- `flush` or `branch_flag` while in IDLE: ignored, with no effect on later cycles.

## Test plan
- Reset release, `RESET_VEC`=0x100, no stall → `ce`: 0,1,1,1…; `pc`: 0x100, 0x100, 0x104, 0x108 on successive edges.
- Stall `stall[0]`=1 for 3 cycles at `pc`=0x20 → `pc` stays 0x20 for 3 cycles, then 0x24.
- `branch_flag`=1, target 0x400, during a stall at `pc`=0x40; stall released 2 cycles later → `pc` holds 0x40, then 0x400, then 0x404.
- Pending target 0x400, then a new `branch_flag` to 0x800 on the release cycle → `pc`=0x800 and the pending branch is dropped. Repeat with `flush`, `new_pc`=0x180 in the same cycle → `pc`=0x180.
- Redirect to 0x1002 with `INST_BYTES`=4 → `pc`=0x1000 and `addr_err` high for exactly one cycle. With `ADDR_W`=8, `pc`=0xFC increments to 0x00.
- Assert `rst` asynchronously mid-cycle with a branch pending → `pc`=`RESET_VEC` and `ce`=0 immediately, before the next edge. After release, no pending redirect is taken.
